// File: rtl/ssd_display_scheduler.sv
// Round-robin display scheduler: grants one requester per dwell period, converts its
// 13-bit value to BCD (shift-add-3) and scans a 4-digit 7-segment display. Optional: LEADING_ZERO_BLANK_EN.
module ssd_display_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100000000,
  parameter int REFRESH_BITS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [13*NUM_SRC-1:0] src_data,
  input  logic                 hold,
  output logic [NUM_SRC-1:0]   src_grant,
  output logic [1:0]           cur_src,
  output logic                 busy,
  output logic [3:0]           Anode,
  output logic [6:0]           LED_out
);

  localparam int DWELL_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [1:0] LAST_RST = 2'(NUM_SRC - 1);

  typedef enum logic [1:0] {ST_ARB, ST_CONVERT, ST_DISPLAY} state_e;

  state_e                  state_q, state_d;
  logic [12:0]             bin_q, bin_d;
  logic [15:0]             bcd_q, bcd_d;
  logic [3:0]              iter_q, iter_d;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic [1:0]              last_q, last_d;
  logic [1:0]              cur_q, cur_d;
  logic [NUM_SRC-1:0]      grant_q, grant_d;
  logic [15:0]             disp_q, disp_d;
  logic                    disp_valid_q, disp_valid_d;
  logic [REFRESH_BITS-1:0] scan_q;

  logic        arb_found;
  logic [1:0]  arb_win;
  logic [12:0] cap_data;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_shift;
  logic        unused_adj_msb;
  logic        dwell_done;
  logic        conv_last;

  // Winner: the held source if it still requests, else first requester after last.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = last_q;
    if (hold && src_req[last_q]) begin
      arb_found = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        if (!arb_found && src_req[(int'(last_q) + k) % NUM_SRC]) begin
          arb_found = 1'b1;
          arb_win   = 2'((int'(last_q) + k) % NUM_SRC);
        end
      end
    end
  end

  always_comb begin
    cap_data = src_data[13*int'(arb_win) +: 13];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                          : bcd_q[4*gi +: 4];
  end

  // Thousands never exceeds 8, so the adjusted MSB is always shifted out as zero.
  assign bcd_shift      = {bcd_adj[14:0], bin_q[12]};
  assign unused_adj_msb = bcd_adj[15];
  assign dwell_done     = (dwell_q == DWELL_LAST);
  assign conv_last      = (iter_q == 4'd12);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ARB;
      bin_q        <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      dwell_q      <= '0;
      last_q       <= LAST_RST;
      cur_q        <= '0;
      grant_q      <= '0;
      disp_q       <= '0;
      disp_valid_q <= 1'b0;
      scan_q       <= '0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      dwell_q      <= dwell_d;
      last_q       <= last_d;
      cur_q        <= cur_d;
      grant_q      <= grant_d;
      disp_q       <= disp_d;
      disp_valid_q <= disp_valid_d;
      scan_q       <= scan_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ARB:     if (arb_found)  state_d = ST_CONVERT;
      ST_CONVERT: if (conv_last)  state_d = ST_DISPLAY;
      ST_DISPLAY: if (dwell_done) state_d = ST_ARB;
      default:                    state_d = ST_ARB;
    endcase
  end

  always_comb begin
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    dwell_d      = dwell_q;
    last_d       = last_q;
    cur_d        = cur_q;
    grant_d      = '0;
    disp_d       = disp_q;
    disp_valid_d = disp_valid_q;
    unique case (state_q)
      ST_ARB: begin
        if (arb_found) begin
          bin_d   = cap_data;
          bcd_d   = '0;
          iter_d  = '0;
          last_d  = arb_win;
          cur_d   = arb_win;
          grant_d = NUM_SRC'(1) << arb_win;
        end
      end
      ST_CONVERT: begin
        bcd_d  = bcd_shift;
        bin_d  = {bin_q[11:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (conv_last) begin
          disp_d       = bcd_shift;
          disp_valid_d = 1'b1;
          dwell_d      = '0;
        end
      end
      ST_DISPLAY: begin
        if (!dwell_done) dwell_d = dwell_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_CONVERT);
    src_grant = grant_q;
    cur_src   = cur_q;
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b0000001;
    endcase
  endfunction

  logic [1:0] digit_sel;
  logic [3:0] digit;
  logic [3:0] anode_sel;
  logic       blank;

  always_comb begin
    digit_sel = scan_q[REFRESH_BITS-1 -: 2];
    case (digit_sel)
      2'd0:    begin digit = disp_q[15:12]; anode_sel = 4'b0111; end
      2'd1:    begin digit = disp_q[11:8];  anode_sel = 4'b1011; end
      2'd2:    begin digit = disp_q[7:4];   anode_sel = 4'b1101; end
      default: begin digit = disp_q[3:0];   anode_sel = 4'b1110; end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (digit_sel)
      2'd0:    blank = (disp_q[15:12] == 4'd0);
      2'd1:    blank = (disp_q[15:8]  == 8'd0);
      2'd2:    blank = (disp_q[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    if (!disp_valid_q || blank) begin
      Anode   = 4'b1111;
      LED_out = 7'b1111111;
    end else begin
      Anode   = anode_sel;
      LED_out = seg7(digit);
    end
  end

endmodule

// File: tb/tb_ssd_display_scheduler.sv
// Randomized bench for ssd_display_scheduler: a transaction-level model predicts grant
// times, winners and displayed digits using plain decimal arithmetic.
module tb_ssd_display_scheduler;
  localparam int NS = 4;
  localparam int D  = 16;
  localparam int RB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   src_req;
  logic [13*NS-1:0] src_data;
  logic            hold;
  logic [NS-1:0]   src_grant;
  logic [1:0]      cur_src;
  logic            busy;
  logic [3:0]      Anode;
  logic [6:0]      LED_out;

  always #5 clk = ~clk;

  ssd_display_scheduler #(.NUM_SRC(NS), .DWELL_CYCLES(D), .REFRESH_BITS(RB)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_data(src_data), .hold(hold),
    .src_grant(src_grant), .cur_src(cur_src), .busy(busy), .Anode(Anode), .LED_out(LED_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model: e = edges since reset release, g = edge of the latest grant.
  int e, g, ready, last_m, cur_m, cap, disp_val;
  bit gvalid, disp_ok;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  default: return 7'b0000001;
    endcase
  endfunction

  task automatic step();
    int w, sel, dig, lim;
    logic [3:0] exp_an, one_hot;
    logic [6:0] exp_led;
    logic [NS-1:0] exp_gnt;
    bit blank;
    @(posedge clk);
    if (rst) begin
      e = 0; g = 0; ready = 1; last_m = NS - 1; cur_m = 0;
      gvalid = 0; disp_ok = 0; disp_val = 0;
    end else begin
      e++;
      if (e >= ready && src_req != '0) begin
        w = -1;
        if (hold && src_req[last_m]) w = last_m;
        else for (int k = 1; k <= NS; k++)
          if (w < 0 && src_req[(last_m + k) % NS]) w = (last_m + k) % NS;
        g = e; gvalid = 1; last_m = w; cur_m = w;
        cap = int'(src_data[13*w +: 13]);
        ready = e + D + 14;
      end
      if (gvalid && e == g + 13) begin
        disp_ok = 1; disp_val = cap;
      end
    end
    #1;
    exp_gnt = (gvalid && e == g) ? NS'(1) << last_m : '0;
    check("src_grant", 32'(src_grant), 32'(exp_gnt));
    check("busy", 32'(busy), 32'(gvalid && e >= g && e <= g + 12));
    check("cur_src", 32'(cur_src), 32'(cur_m));
    exp_an = 4'b1111; exp_led = 7'b1111111;
    if (disp_ok) begin
      sel = (e % (1 << RB)) >> (RB - 2);
      case (sel)
        0: begin dig = disp_val / 1000;      lim = 1000; end
        1: begin dig = (disp_val / 100) % 10; lim = 100; end
        2: begin dig = (disp_val / 10) % 10;  lim = 10;  end
        default: begin dig = disp_val % 10;   lim = 0;   end
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      blank = (disp_val < lim);
`else
      blank = 0;
`endif
      one_hot = 4'b1000;
      if (!blank) begin
        exp_an  = ~(one_hot >> sel);
        exp_led = seg_of(dig);
      end
    end
    check("Anode", 32'(Anode), 32'(exp_an));
    check("LED_out", 32'(LED_out), 32'(exp_led));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; src_req = 4'b1111; hold = 1'b0;
    for (int i = 0; i < NS; i++) src_data[13*i +: 13] = 13'($urandom_range(0, 8191));
    run(3);
    rst = 1'b0;
    run(40);

    src_req = 4'b0100; src_data[38:26] = 13'd1234;
    run(70);

    src_req = 4'b0001; src_data[12:0] = 13'd8191;
    run(35);
    src_data[12:0] = 13'd0;
    run(40);

    src_req = 4'b1111;
    src_data = {13'd789, 13'd3456, 13'd2000, 13'd105};
    run(160);

    src_req = 4'b0011; hold = 1'b1;
    run(100);
    hold = 1'b0;
    run(70);

    // Abort in the 7th CONVERT cycle; the partial BCD must never reach the display.
    src_req = 4'b0001; src_data[12:0] = 13'd4321;
    for (int i = 0; i < 100; i++) begin
      if (gvalid && e == g + 6) break;
      step();
    end
    check("conv7_reached", 32'(gvalid && e == g + 6), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(60);

    for (int blk = 0; blk < 30; blk++) begin
      src_req = NS'($urandom_range(0, 15));
      hold    = 1'($urandom_range(0, 1));
      for (int i = 0; i < NS; i++)
        src_data[13*i +: 13] = ($urandom_range(0, 3) == 0) ? 13'd8191
                                                            : 13'($urandom_range(0, 8191));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      run($urandom_range(5, 60));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
